// File: rtl/pc_fetch_unit.sv
// PC holder and instruction fetcher feeding the single-cycle Control decoder.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCw,
    input  logic        branch,
    input  logic        jump,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [15:0] imm16,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic [31:0] instr_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_br_tgt   = w_pc_plus4 + w_br_off;
    assign w_jmp_tgt  = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

    // Next-PC select: jump outranks branch, otherwise fall through
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = w_jmp_tgt;
        end else if (branch) begin
            w_next_pc = w_br_tgt;
        end
    end

    // Fetch/execute/halt sequencer holding PC and the latched instruction
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_FETCH;
            r_pc    <= PC_INIT;
            r_instr <= 32'h0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (PCw) begin
                        r_pc    <= w_next_pc;
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_HALT;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Request is gated by Reset so it drops the instant reset asserts
    assign imem_req    = (r_state == S_FETCH) && Reset;
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_EXEC);
    assign halted      = (r_state == S_HALT);
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign func        = r_instr[5:0];
    assign imm16       = r_instr[15:0];

`ifdef INSTR_COUNT_EN
    logic [31:0] r_instr_cnt;

    // Count every instruction that commits a new PC; the halt is excluded
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_instr_cnt <= 32'h0;
        end else if ((r_state == S_EXEC) && PCw) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign instr_cnt = r_instr_cnt;
`else
    assign instr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: driver pushes expected pc/instr,
// monitor pops and compares on every instr_valid cycle.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic        PCw;
    logic        branch;
    logic        jump;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic [31:0] instr_cnt;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    exp_t e;

`ifdef INSTR_COUNT_EN
    localparam logic [31:0] CNT_P1 = 32'd10;
    localparam logic [31:0] CNT_P2 = 32'd5;
`else
    localparam logic [31:0] CNT_P1 = 32'd0;
    localparam logic [31:0] CNT_P2 = 32'd0;
`endif

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .PCw        (PCw),
        .branch     (branch),
        .jump       (jump),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .op         (op),
        .func       (func),
        .imm16      (imm16),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .halted     (halted),
        .instr_cnt  (instr_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every EXEC cycle must match the oldest expected entry
    always @(negedge CLK) begin
        if (instr_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_pc=%h expected=none", pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_instr", instr, e.instr);
                chk("sb_op", {26'h0, op}, {26'h0, e.instr[31:26]});
                chk("sb_func", {26'h0, func}, {26'h0, e.instr[5:0]});
                chk("sb_imm16", {16'h0, imm16}, {16'h0, e.instr[15:0]});
                chk("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
            end
        end
    end

    // One instruction: fetch (with stalls), exec with Control response
    task automatic run_entry(input logic [31:0] epc, input logic [31:0] word,
                             input int stall, input logic pcw,
                             input logic br, input logic jmp);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!imem_req) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout actual_req=0 expected_req=1 pc=%h", epc);
            return;
        end
        sb.push_back('{pc: epc, instr: word});
        PCw    = 1'b0;
        branch = 1'b1;
        jump   = 1'b1;
        for (int s = 0; s < stall; s++) begin
            imem_ready = 1'b0;
            imem_rdata = 32'hBAD0_0000;
            @(posedge CLK);
            @(negedge CLK);
            chk("stall_addr", imem_addr, epc);
            chk("stall_valid", {31'h0, instr_valid}, 32'h0);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        @(posedge CLK);
        @(negedge CLK);
        chk("exec_valid", {31'h0, instr_valid}, 32'h1);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        PCw    = pcw;
        branch = br;
        jump   = jmp;
        @(posedge CLK);
        @(negedge CLK);
        imem_ready = 1'b0;
        PCw    = 1'b0;
        branch = 1'b1;
        jump   = 1'b1;
        chk("instr_hold", instr, word);
    endtask

    task automatic check_halt(input logic [31:0] hpc, input logic [31:0] cnt);
        imem_ready = 1'b1;
        imem_rdata = 32'h1234_5678;
        PCw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("halt_flag", {31'h0, halted}, 32'h1);
            chk("halt_req", {31'h0, imem_req}, 32'h0);
            chk("halt_valid", {31'h0, instr_valid}, 32'h0);
            chk("halt_pc", pc, hpc);
        end
        chk("instr_cnt", instr_cnt, cnt);
        imem_ready = 1'b0;
        PCw = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        Reset      = 1'b0;
        PCw        = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        @(negedge CLK);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_cnt", instr_cnt, 32'h0);
        imem_ready = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        chk("rel_req", {31'h0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0);

        run_entry(32'h0000_0000, 32'h2008_0005, 0, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_0004, 32'h8C09_0004, 3, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_0008, 32'h0128_5020, 0, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_000C, 32'hAC0A_0008, 0, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_0010, 32'h1000_FFFE, 0, 1'b1, 1'b1, 1'b0);
        run_entry(32'h0000_000C, 32'h0800_0040, 0, 1'b1, 1'b1, 1'b1);
        run_entry(32'h0000_0100, 32'h1000_FFBC, 1, 1'b1, 1'b1, 1'b0);
        run_entry(32'hFFFF_FFF4, 32'h0BFF_FFFF, 0, 1'b1, 1'b0, 1'b1);
        run_entry(32'hFFFF_FFFC, 32'h0000_0020, 0, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_0000, 32'h1000_0007, 0, 1'b1, 1'b1, 1'b0);
        run_entry(32'h0000_0020, 32'hFC00_003F, 0, 1'b0, 1'b0, 1'b0);
        check_halt(32'h0000_0020, CNT_P1);
        chk("halt_instr", instr, 32'hFC00_003F);

        #2 Reset = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_halted", {31'h0, halted}, 32'h0);
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_cnt", instr_cnt, 32'h0);
        @(negedge CLK);
        Reset = 1'b1;
        imem_ready = 1'b0;
        @(negedge CLK);
        chk("mid_req", {31'h0, imem_req}, 32'h1);
        imem_ready = 1'b1;
        imem_rdata = 32'h7777_7777;
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        imem_ready = 1'b0;
        @(negedge CLK);
        chk("mid_rst_instr", instr, 32'h0);
        Reset = 1'b1;
        #1;

        run_entry(32'h0000_0000, 32'h2001_0011, 0, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_0004, 32'h2002_0022, 0, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_0008, 32'h2003_0033, 0, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_000C, 32'h2004_0044, 2, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_0010, 32'h2005_0055, 0, 1'b1, 1'b0, 1'b0);
        run_entry(32'h0000_0014, 32'hFC00_003F, 0, 1'b0, 1'b0, 1'b0);
        check_halt(32'h0000_0014, CNT_P2);

        @(negedge CLK);
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
